// File: rtl/asu_riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asu_riscv_pkg
// Description : Shared definitions for the RV32M multiply/divide unit.
//               Holds the md operator encodings, the divider FSM state
//               encoding and a small magnitude helper.
// Revision    : 1.0 - initial release
// ============================================================================
package asu_riscv_pkg;

   // md operator encodings: bit 0 selects unsigned, bit 1 selects remainder
   localparam logic [1:0] MD_OP_DIV  = 2'b00;
   localparam logic [1:0] MD_OP_DIVU = 2'b01;
   localparam logic [1:0] MD_OP_REM  = 2'b10;
   localparam logic [1:0] MD_OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_CALC = 2'b01,
      DIV_FIX  = 2'b10,
      DIV_DONE = 2'b11
   } div_state_e;

   // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
   // correct unsigned magnitude of the most negative value.
   function automatic logic [31:0] abs_val(input logic [31:0] x, input logic neg);
      return neg ? (~x + 32'd1) : x;
   endfunction

endpackage : asu_riscv_pkg
`default_nettype wire

// File: rtl/asu_riscv_div_step.sv
`default_nettype none
// ============================================================================
// Module      : asu_riscv_div_step
// Description : One combinational radix-2 restoring division step.
//               Shifts the next dividend bit into the partial remainder,
//               trial-subtracts the divisor and restores on underflow.
// Ports       : rem_i     [32:0] current partial remainder
//               q_msb_i          next dividend bit (quotient register MSB)
//               div_i     [31:0] divisor magnitude
//               new_rem_o [32:0] updated partial remainder
//               q_bit_o          quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module asu_riscv_div_step (
   input  logic [32:0] rem_i,
   input  logic        q_msb_i,
   input  logic [31:0] div_i,
   output logic [32:0] new_rem_o,
   output logic        q_bit_o
);

   logic [33:0] w_shifted;
   logic [33:0] w_trial;

   // The partial remainder is always below the divisor, so bit 32 of rem_i
   // is zero in practice; carrying it through the full-width subtract keeps
   // the step correct in isolation for any input.
   assign w_shifted = {rem_i, q_msb_i};
   assign w_trial   = w_shifted - {2'b00, div_i};

   assign q_bit_o   = ~w_trial[33];
   assign new_rem_o = q_bit_o ? w_trial[32:0] : w_shifted[32:0];

endmodule : asu_riscv_div_step
`default_nettype wire

// File: rtl/asu_riscv_divider.sv
`default_nettype none
// ============================================================================
// Module      : asu_riscv_divider
// Description : Multi-cycle radix-2 restoring divider for RV32M DIV, DIVU,
//               REM and REMU. 32 iterations plus a sign-fix cycle; divide
//               by zero and signed overflow complete in one cycle.
// Ports       : clk, nrst (async, active-low)
//               start_i       request a division (sampled in IDLE only)
//               kill_i        abort the current operation, no result
//               operator_i[1:0] 00 DIV, 01 DIVU, 10 REM, 11 REMU
//               op_a_i/op_b_i dividend / divisor, stable while busy_o
//               busy_o        high whenever not IDLE
//               valid_o       one-cycle result strobe
//               result_o[31:0] quotient or remainder, held between ops
// Revision    : 1.0 - initial release
// ============================================================================
module asu_riscv_divider
   import asu_riscv_pkg::*;
(
   input  logic        clk,
   input  logic        nrst,
   input  logic        start_i,
   input  logic        kill_i,
   input  logic [1:0]  operator_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   output logic        busy_o,
   output logic        valid_o,
   output logic [31:0] result_o
);

   div_state_e  r_state;
   div_state_e  w_next_state;

   logic        r_rem_sel;
   logic [31:0] r_quot;
   logic [31:0] r_div;
   logic [32:0] r_rem;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [4:0]  r_count;
   logic [31:0] r_result;
   logic        r_valid;
   logic        r_busy;

   logic        w_signed;
   logic        w_sign_a;
   logic        w_sign_b;
   logic        w_div_zero;
   logic        w_overflow;
   logic        w_accept;
   logic [32:0] w_new_rem;
   logic        w_q_bit;

   assign w_signed   = ~operator_i[0];
   assign w_sign_a   = w_signed & op_a_i[31];
   assign w_sign_b   = w_signed & op_b_i[31];
   assign w_div_zero = (op_b_i == 32'd0);
   assign w_overflow = w_signed && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
   assign w_accept   = (r_state == DIV_IDLE) && start_i && !kill_i;

   asu_riscv_div_step u_step (
      .rem_i     (r_rem),
      .q_msb_i   (r_quot[31]),
      .div_i     (r_div),
      .new_rem_o (w_new_rem),
      .q_bit_o   (w_q_bit)
   );

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= DIV_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state; kill_i overrides every transition out of a busy state
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         DIV_IDLE: begin
            if (start_i && !kill_i) begin
               w_next_state = (w_div_zero || w_overflow) ? DIV_DONE : DIV_CALC;
            end
         end
         DIV_CALC: begin
            if (kill_i) begin
               w_next_state = DIV_IDLE;
            end else if (r_count == 5'd31) begin
               w_next_state = DIV_FIX;
            end
         end
         DIV_FIX: begin
            w_next_state = kill_i ? DIV_IDLE : DIV_DONE;
         end
         DIV_DONE: begin
            w_next_state = DIV_IDLE;
         end
         default: begin
            w_next_state = DIV_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_rem_sel <= 1'b0;
         r_quot    <= 32'd0;
         r_div     <= 32'd0;
         r_rem     <= 33'd0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_count   <= 5'd0;
         r_result  <= 32'd0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         // Both outputs follow the next state so they line up with it
         r_valid <= (w_next_state == DIV_DONE);
         r_busy  <= (w_next_state != DIV_IDLE);

         if (w_accept) begin
            r_rem_sel <= operator_i[1];
            if (w_div_zero) begin
               r_result <= operator_i[1] ? op_a_i : 32'hFFFF_FFFF;
            end else if (w_overflow) begin
               r_result <= operator_i[1] ? 32'd0 : 32'h8000_0000;
            end else begin
               r_quot  <= abs_val(op_a_i, w_sign_a);
               r_div   <= abs_val(op_b_i, w_sign_b);
               r_rem   <= 33'd0;
               r_neg_q <= w_sign_a ^ w_sign_b;
               r_neg_r <= w_sign_a;
               r_count <= 5'd0;
            end
         end

         if ((r_state == DIV_CALC) && !kill_i) begin
            r_rem   <= w_new_rem;
            r_quot  <= {r_quot[30:0], w_q_bit};
            r_count <= r_count + 5'd1;
         end

         if ((r_state == DIV_FIX) && !kill_i) begin
            if (r_rem_sel) begin
               r_result <= abs_val(r_rem[31:0], r_neg_r);
            end else begin
               r_result <= abs_val(r_quot, r_neg_q);
            end
         end
      end
   end

   assign busy_o   = r_busy;
   assign valid_o  = r_valid;
   assign result_o = r_result;

endmodule : asu_riscv_divider
`default_nettype wire

// File: tb/tb_asu_riscv_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_asu_riscv_divider
// Description : Self-checking bench for asu_riscv_divider. A table of
//               directed vectors with hand-computed results and latencies,
//               followed by kill, ignored-start and mid-operation reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asu_riscv_divider;

   logic        clk;
   logic        nrst;
   logic        start_i;
   logic        kill_i;
   logic [1:0]  operator_i;
   logic [31:0] op_a_i;
   logic [31:0] op_b_i;
   logic        busy_o;
   logic        valid_o;
   logic [31:0] result_o;

   int n_pass;
   int n_total;

   asu_riscv_divider dut (
      .clk        (clk),
      .nrst       (nrst),
      .start_i    (start_i),
      .kill_i     (kill_i),
      .operator_i (operator_i),
      .op_a_i     (op_a_i),
      .op_b_i     (op_b_i),
      .busy_o     (busy_o),
      .valid_o    (valid_o),
      .result_o   (result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        special;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Issues one operation. When aligned=1 the caller is already at a negedge
   // and start_i is driven immediately. Returns the result, the number of
   // posedges after E0 before valid_o was seen, and the busy cycle count.
   task automatic run_op(input bit aligned, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int edges, output int busy_n);
      if (!aligned) @(negedge clk);
      operator_i = op;
      op_a_i     = a;
      op_b_i     = b;
      start_i    = 1'b1;
      @(posedge clk);               // E0
      @(negedge clk);
      start_i = 1'b0;
      edges   = 0;
      busy_n  = 0;
      while (!valid_o && edges < 60) begin
         if (busy_o) busy_n++;
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      if (busy_o) busy_n++;
      res = result_o;
   endtask

   initial begin
      logic [31:0] res;
      int          edges;
      int          busy_n;
      logic        saw_valid;
      logic [31:0] last_exp;

      n_pass     = 0;
      n_total    = 0;
      nrst       = 1'b0;
      start_i    = 1'b0;
      kill_i     = 1'b0;
      operator_i = 2'b00;
      op_a_i     = 32'd0;
      op_b_i     = 32'd0;

      vecs[0]  = '{2'b00, 32'd100,        32'd7,          32'h0000_000E, 1'b0};
      vecs[1]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 1'b0};
      vecs[2]  = '{2'b11, 32'hFFFF_FFF9,  32'd2,          32'h0000_0001, 1'b0};
      vecs[3]  = '{2'b01, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC, 1'b0};
      vecs[4]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1};
      vecs[5]  = '{2'b10, 32'd5,          32'd0,          32'h0000_0005, 1'b1};
      vecs[6]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1};
      vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1};
      vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1'b1};
      vecs[9]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1'b0};
      vecs[10] = '{2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2, 1'b0};
      vecs[11] = '{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE, 1'b0};
      vecs[12] = '{2'b00, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2, 1'b0};
      vecs[13] = '{2'b10, 32'd100,        32'hFFFF_FFF9,  32'h0000_0002, 1'b0};
      vecs[14] = '{2'b11, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0000_000F, 1'b0};
      vecs[15] = '{2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000, 1'b0};
      vecs[16] = '{2'b10, 32'h8000_0000,  32'd2,          32'h0000_0000, 1'b0};
      vecs[17] = '{2'b01, 32'd1000,       32'd3,          32'h0000_014D, 1'b0};
      last_exp = 32'h0000_014D;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy",   {31'd0, busy_o},  32'd0);
      chk("reset_valid",  {31'd0, valid_o}, 32'd0);
      chk("reset_result", result_o,         32'd0);
      nrst = 1'b1;

      // Vector table
      for (int i = 0; i < NV; i++) begin
         run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, res, edges, busy_n);
         chk($sformatf("v%0d_result", i), res, vecs[i].exp);
         chk($sformatf("v%0d_latency", i), edges, vecs[i].special ? 32'd0 : 32'd33);
         chk($sformatf("v%0d_busy_cycles", i), busy_n, vecs[i].special ? 32'd1 : 32'd34);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_valid_pulse", i), {31'd0, valid_o}, 32'd0);
         chk($sformatf("v%0d_idle", i), {31'd0, busy_o}, 32'd0);
      end

      // Kill at E10 of a DIV, with an ignored start pulse at E5
      @(negedge clk);
      operator_i = 2'b00;
      op_a_i     = 32'd1000;
      op_b_i     = 32'd3;
      start_i    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_i   = 1'b0;
      saw_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (valid_o) saw_valid = 1'b1;
         start_i = (k == 4);
      end
      start_i = 1'b0;
      chk("kill_busy_before", {31'd0, busy_o}, 32'd1);
      kill_i = 1'b1;
      @(posedge clk);               // E11
      @(negedge clk);
      kill_i = 1'b0;
      if (valid_o) saw_valid = 1'b1;
      chk("kill_busy_after", {31'd0, busy_o},    32'd0);
      chk("kill_no_valid",   {31'd0, saw_valid}, 32'd0);
      chk("kill_result_held", result_o,          last_exp);
      run_op(1'b1, 2'b00, 32'd1000, 32'hFFFF_FFFD, res, edges, busy_n);
      chk("after_kill_result",  res,   32'hFFFF_FEB3);
      chk("after_kill_latency", edges, 32'd33);

      // Asynchronous reset at E20 of a DIVU
      @(negedge clk);
      operator_i = 2'b01;
      op_a_i     = 32'd12345;
      op_b_i     = 32'd17;
      start_i    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      repeat (19) @(posedge clk);
      @(posedge clk);               // E20
      #1 nrst = 1'b0;
      #1;
      chk("rst_busy",   {31'd0, busy_o},  32'd0);
      chk("rst_valid",  {31'd0, valid_o}, 32'd0);
      chk("rst_result", result_o,         32'd0);
      @(negedge clk);
      nrst = 1'b1;
      run_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0000_0010, res, edges, busy_n);
      chk("post_rst_result",  res,   32'h0FFF_FFFF);
      chk("post_rst_latency", edges, 32'd33);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_asu_riscv_divider
`default_nettype wire
